// File: rtl/result_collector.sv
// Result collector: captures 256-bit engine result columns into a small FIFO and
// streams them out as 32-bit words. Optional running XOR checksum: RESULT_COLLECTOR_CHECKSUM_EN.
module result_collector #(
    parameter int NUM_COLS   = 32,
    parameter int COL_W      = 256,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              AnsValid,
    input  logic [4:0]        ResultAddress,
    input  logic [COL_W-1:0]  FinalDataOut,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [4:0]        out_col,
    output logic [2:0]        out_word,
    output logic              out_last,
    output logic              done,
    output logic              addr_err,
    output logic              ovf_err,
    output logic [WORD_W-1:0] checksum
);

    localparam int WPC = COL_W / WORD_W;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(NUM_COLS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_W-1:0] fifo_data [FIFO_DEPTH];
    logic [4:0]       fifo_tag  [FIFO_DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;

    logic             ans_q;
    logic             cap;
    logic             wr_en;
    logic             pop;
    logic             advance;
    logic             xfer;
    logic [CW-1:0]    exp_col;
    logic [CW-1:0]    sent_cols;
    logic [COL_W-1:0] shift;
    logic [4:0]       col_tag;
    logic [2:0]       word_idx;
    logic             last_word;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign cap       = AnsValid & ~ans_q;
    assign out_valid = (state == SEND);
    assign xfer      = out_valid & out_ready;
    assign last_word = (word_idx == 3'(WPC - 1));

    // A same-cycle pop frees a slot, so a full FIFO can still take the new column.
    assign wr_en = cap && (exp_col != CW'(NUM_COLS)) && (state != DONE) && (!fifo_full || pop);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!last_word) begin
                        advance = 1'b1;
                    end else if (sent_cols == CW'(NUM_COLS - 1)) begin
                        state_next = DONE;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            fifo_data[wr_ptr[PW-1:0]] <= FinalDataOut;
            fifo_tag[wr_ptr[PW-1:0]]  <= ResultAddress;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ans_q     <= 1'b0;
            exp_col   <= '0;
            sent_cols <= '0;
            addr_err  <= 1'b0;
            ovf_err   <= 1'b0;
            shift     <= '0;
            col_tag   <= '0;
            word_idx  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ans_q     <= 1'b0;
            exp_col   <= '0;
            sent_cols <= '0;
            addr_err  <= 1'b0;
            ovf_err   <= 1'b0;
            shift     <= '0;
            col_tag   <= '0;
            word_idx  <= '0;
        end else begin
            ans_q <= AnsValid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cap) begin
                if (exp_col != CW'(NUM_COLS)) begin
                    exp_col <= exp_col + 1'b1;
                end
                if (CW'(ResultAddress) != exp_col) begin
                    addr_err <= 1'b1;
                end
                if (!wr_en) begin
                    ovf_err <= 1'b1;
                end
            end
            // The column being serialised lives in the shift register, not the FIFO.
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                shift    <= fifo_data[rd_ptr[PW-1:0]];
                col_tag  <= fifo_tag[rd_ptr[PW-1:0]];
                word_idx <= '0;
            end else if (advance) begin
                shift    <= shift << WORD_W;
                word_idx <= word_idx + 1'b1;
            end
            if (xfer && last_word) begin
                sent_cols <= sent_cols + 1'b1;
            end
        end
    end

    assign out_data = out_valid ? shift[COL_W-1 -: WORD_W] : '0;
    assign out_col  = out_valid ? col_tag : '0;
    assign out_word = out_valid ? word_idx : '0;
    assign out_last = out_valid && last_word && (sent_cols == CW'(NUM_COLS - 1));
    assign done     = (state == DONE);

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic [WORD_W-1:0] csum;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ out_data;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule
